// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: widths, sequencer states, command register layout.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 5;
    localparam int DMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // The command register is sized by the package widths.
    typedef struct packed {
        logic                   write;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic                   id;
    } cmd_t;

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way grant logic. DMEM_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module dmem_rr_arbiter (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

`ifdef DMEM_ARB_RR_EN
    // On a conflict, the requester that did not win last time gets the grant.
    assign grant0 = valid0 && (!valid1 || last_grant);
    assign grant1 = valid1 && (!valid0 || !last_grant);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant0 = valid0;
    assign grant1 = valid1 && !valid0;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto the single-port data memory: IDLE accepts, ISSUE drives the port, RESP returns.
// DMEM_ARB_RR_EN enables round-robin arbitration; the default build uses fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_en,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state, state_nx;
    cmd_t   cmd;
    logic   grant0, grant1, last_grant, accept;

`ifdef DMEM_ARB_RR_EN
    // Reset to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clock) begin
        if (!reset_n)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant1;
    end
`else
    assign last_grant = 1'b1;
`endif

    dmem_rr_arbiter u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign accept = (state == IDLE) && (grant0 || grant1);

    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cmd <= '0;
        end else if (accept) begin
            cmd.write <= grant1 ? req1_write : req0_write;
            cmd.addr  <= grant1 ? req1_addr  : req0_addr;
            cmd.wdata <= grant1 ? req1_wdata : req0_wdata;
            cmd.id    <= grant1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Port fields are zeroed outside ISSUE and mem_read idles high so the memory never sees a stray write.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        mem_en     = 1'b0;
        mem_read   = 1'b1;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_read  = !cmd.write;
                mem_addr  = cmd.addr;
                mem_wdata = cmd.wdata;
            end
            RESP: begin
                rsp0_valid = !cmd.id;
                rsp1_valid = cmd.id;
                if (!cmd.write) begin
                    if (cmd.id) rsp1_rdata = mem_rdata;
                    else        rsp0_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps plus random traffic against a transaction-level model.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
    logic [4:0]  req0_addr = '0, req1_addr = '0;
    logic [15:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, mem_read;
    logic [15:0] rsp0_rdata, rsp1_rdata, mem_wdata;
    logic [4:0]  mem_addr;
    logic [15:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    // Pending request per requester, and the reference model state.
    bit          p_v[2];
    bit          p_w[2];
    logic [4:0]  p_a[2];
    logic [15:0] p_d[2];
    logic [15:0] m_mem[32];
    bit          m_lg;
    bit          preload = 1'b1;

    // Behavioural single-port memory: registered read data, write on the edge.
    logic [15:0] mem[32];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_read) mem_rdata <= mem[mem_addr];
            else          mem[mem_addr] <= mem_wdata;
        end
    end

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_en     (mem_en),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = p_v[0]; req0_write = p_w[0]; req0_addr = p_a[0]; req0_wdata = p_d[0];
        req1_valid = p_v[1]; req1_write = p_w[1]; req1_addr = p_a[1]; req1_wdata = p_d[1];
    endtask

    function automatic int exp_grant();
        if (p_v[0] && !p_v[1]) return 0;
        if (p_v[1] && !p_v[0]) return 1;
`ifdef DMEM_ARB_RR_EN
        return m_lg ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    task automatic quiet_checks(input string tag);
        chk({tag, "_ready0"}, 32'(req0_ready), 0);
        chk({tag, "_ready1"}, 32'(req1_ready), 0);
        chk({tag, "_rsp0"},   32'(rsp0_valid), 0);
        chk({tag, "_rsp1"},   32'(rsp1_valid), 0);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_rd"}, 32'(mem_read), 1);
    endtask

    // One full transaction from IDLE; entered and left just after a rising edge with the DUT in IDLE.
    task automatic do_cycle(output int dut_win);
        int          win;
        logic [15:0] exp_rd;
        drive();
        win = exp_grant();
        @(negedge clock);
        dut_win = req0_ready ? 0 : (req1_ready ? 1 : -1);
        chk("ready0", 32'(req0_ready), 32'(win == 0));
        chk("ready1", 32'(req1_ready), 32'(win == 1));
        chk("idle_mem_en", 32'(mem_en), 0);
        @(posedge clock); #1;
        exp_rd = p_w[win] ? 16'h0 : m_mem[p_a[win]];
        if (p_w[win]) m_mem[p_a[win]] = p_d[win];
        m_lg = (win == 1);
        p_v[win] = 1'b0;
        drive();
        @(negedge clock);
        chk("issue_mem_en", 32'(mem_en), 1);
        chk("issue_mem_read", 32'(mem_read), 32'(!p_w[win]));
        chk("issue_mem_addr", 32'(mem_addr), 32'(p_a[win]));
        chk("issue_mem_wdata", 32'(mem_wdata), 32'(p_d[win]));
        chk("issue_ready0", 32'(req0_ready), 0);
        chk("issue_ready1", 32'(req1_ready), 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("rsp0_valid", 32'(rsp0_valid), 32'(win == 0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(win == 1));
        chk("rsp0_rdata", 32'(rsp0_rdata), (win == 0) ? 32'(exp_rd) : 0);
        chk("rsp1_rdata", 32'(rsp1_rdata), (win == 1) ? 32'(exp_rd) : 0);
        chk("resp_mem_en", 32'(mem_en), 0);
        chk("resp_ready0", 32'(req0_ready), 0);
        @(posedge clock); #1;
    endtask

    initial begin
        int w;
        int order[4];
        for (int i = 0; i < 32; i++) m_mem[i] = 16'(i);
        m_lg = 1'b1;
        for (int i = 0; i < 2; i++) begin p_v[i] = 0; p_w[i] = 0; p_a[i] = '0; p_d[i] = '0; end

        // Reset state
        repeat (3) @(posedge clock);
        #1 preload = 1'b0;
        @(negedge clock);
        quiet_checks("reset");
        chk("reset_mem_addr", 32'(mem_addr), 0);
        chk("reset_mem_wdata", 32'(mem_wdata), 0);
        chk("reset_rsp0_rdata", 32'(rsp0_rdata), 0);
        chk("reset_rsp1_rdata", 32'(rsp1_rdata), 0);
        @(posedge clock); #1 reset_n = 1'b1;

        // Single-requester load of addr 5
        p_v[0] = 1; p_w[0] = 0; p_a[0] = 5'd5; p_d[0] = 16'h0;
        do_cycle(w);
        chk("load5_winner", 32'(w), 0);

        // Store then load on requester 1
        p_v[1] = 1; p_w[1] = 1; p_a[1] = 5'd12; p_d[1] = 16'hBEEF;
        do_cycle(w);
        p_v[1] = 1; p_w[1] = 0; p_a[1] = 5'd12; p_d[1] = 16'h0;
        do_cycle(w);

        // Continuous conflict: loads to 3 (req0) and 7 (req1)
`ifdef DMEM_ARB_RR_EN
        order = '{0, 1, 0, 1};
`else
        order = '{0, 0, 0, 0};
`endif
        p_v[0] = 1; p_w[0] = 0; p_a[0] = 5'd3; p_d[0] = 16'h0;
        p_v[1] = 1; p_w[1] = 0; p_a[1] = 5'd7; p_d[1] = 16'h0;
        for (int k = 0; k < 4; k++) begin
            do_cycle(w);
            chk("conflict_order", 32'(w), 32'(order[k]));
            if (w >= 0) p_v[w] = 1;
        end
        p_v[0] = 0;
        do_cycle(w);
        chk("conflict_req1_served", 32'(w), 1);
        p_v[0] = 0; p_v[1] = 0;

        // Reset asserted while a store is in ISSUE
        p_v[0] = 1; p_w[0] = 1; p_a[0] = 5'd9; p_d[0] = 16'h1234;
        drive();
        @(negedge clock);
        chk("rst_ready0", 32'(req0_ready), 1);
        @(posedge clock); #1;
        p_v[0] = 0; drive();
        @(negedge clock);
        chk("rst_issue_mem_en", 32'(mem_en), 1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        // The store's write edge coincides with the reset edge, so the memory takes the data.
        m_mem[9] = 16'h1234;
        m_lg = 1'b1;
        @(negedge clock);
        quiet_checks("rst_a");
        @(posedge clock); #1;
        @(negedge clock);
        quiet_checks("rst_b");
        @(posedge clock); #1 reset_n = 1'b1;
        p_v[0] = 1; p_w[0] = 0; p_a[0] = 5'd9; p_d[0] = 16'h0;
        do_cycle(w);
        chk("post_rst_winner", 32'(w), 0);

        // Idle for 20 cycles
        drive();
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            quiet_checks("idle");
            chk("idle_rsp0_rdata", 32'(rsp0_rdata), 0);
            chk("idle_rsp1_rdata", 32'(rsp1_rdata), 0);
        end
        @(posedge clock); #1;

        // Random traffic; a losing request stays pending until served
        for (int k = 0; k < 60; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_v[r] && $urandom_range(0, 1) == 1) begin
                    p_v[r] = 1;
                    p_w[r] = 1'($urandom_range(0, 1));
                    p_a[r] = 5'($urandom_range(0, 31));
                    p_d[r] = 16'($urandom);
                end
            end
            if (!p_v[0] && !p_v[1]) begin
                p_v[0] = 1; p_w[0] = 0; p_a[0] = 5'($urandom_range(0, 31)); p_d[0] = 16'($urandom);
            end
            do_cycle(w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
